// File: rtl/regfile_write_buffer_if.sv
// Bus bundle between a register write-back producer and the write buffer:
// request handshake, register file write port, bypass lookup and occupancy.
interface regfile_write_buffer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned BUF_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    logic             inValid;
    logic             inReady;
    logic [DEPTH-1:0] inAddr;
    logic [WIDTH-1:0] inData;

    logic             rfWriteStall;
    logic             rfWriteEnable;
    logic [DEPTH-1:0] rfWriteAddr;
    logic [WIDTH-1:0] rfWriteData;

    logic [DEPTH-1:0] lookupAddr;
    logic             lookupHit;
    logic [WIDTH-1:0] lookupData;

    logic [CNT_W-1:0] count;

    // Producer / register file side
    modport master (
        output inValid, inAddr, inData, rfWriteStall, lookupAddr,
        input  inReady, rfWriteEnable, rfWriteAddr, rfWriteData,
               lookupHit, lookupData, count
    );

    // Buffer side
    modport slave (
        input  inValid, inAddr, inData, rfWriteStall, lookupAddr,
        output inReady, rfWriteEnable, rfWriteAddr, rfWriteData,
               lookupHit, lookupData, count
    );
endinterface

// File: rtl/regfile_write_buffer.sv
// In-order write-back buffer in front of the register file write port.
// Queues write requests, drains one per unstalled cycle, and offers a
// combinational bypass returning the youngest pending value for an address.
module regfile_write_buffer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned BUF_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    regfile_write_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [BUF_DEPTH-1:0] valid_q;
    logic [DEPTH-1:0]     addr_q [BUF_DEPTH];
    logic [WIDTH-1:0]     data_q [BUF_DEPTH];

    logic full;
    logic empty;
    logic ready;
    logic push;
    logic drain;

    // Handshake and drain decode; ready depends only on occupancy and reset
    always_comb begin
        full  = (count_q == CNT_W'(BUF_DEPTH));
        empty = (count_q == '0);
        ready = reset && !full;
        push  = bus.inValid && ready;
        drain = !empty && !bus.rfWriteStall;
    end

    // Register file write port driven from the head entry
    always_comb begin
        bus.inReady       = ready;
        bus.rfWriteEnable = drain;
        bus.rfWriteAddr   = '0;
        bus.rfWriteData   = '0;
        bus.count         = count_q;
        if (!empty) begin
            bus.rfWriteAddr = addr_q[rd_ptr_q];
            bus.rfWriteData = data_q[rd_ptr_q];
        end
    end

    // Bypass: scan oldest to youngest so the last match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.lookupHit  = 1'b0;
        bus.lookupData = '0;
        idx            = '0;
        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == bus.lookupAddr)) begin
                bus.lookupHit  = 1'b1;
                bus.lookupData = data_q[idx];
            end
        end
    end

    // Pointer, occupancy and valid-bit state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (drain) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            // Push and drain never target the same slot: push needs not-full,
            // drain needs not-empty, so wr_ptr != rd_ptr whenever both fire.
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            unique case ({push, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload storage; qualified by valid_q/count_q so needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.inAddr;
            data_q[wr_ptr_q] <= bus.inData;
        end
    end
endmodule
